// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake.
// Single-cycle AND, OR, ADD, SUB, SLT and NOR; illegal opcodes complete in
// one cycle with err_o set. Defining ALU_MUL_EN compiles in an unsigned
// iterative shift-add multiply (ctrl 1000) that takes WIDTH cycles; without
// it, ctrl 1000 is treated as illegal and the block is always ready.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             err_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] product;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product_next;
  logic [CNT_W-1:0]   cnt_next;
`endif

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             illegal;
  logic             is_mul;
  logic             accept;

  // Shared adder: SUB and SLT both use A + ~B + 1.
  assign sub     = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
  assign b_eff   = src2_i ^ {WIDTH{sub}};
  assign sum     = {1'b0, src1_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign add_ovf = (src1_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != src1_i[WIDTH-1]);

`ifdef ALU_MUL_EN
  assign ready_o = (state == S_IDLE);
  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign product_next = product + (mplier[0] ? mcand : '0);
  assign cnt_next     = cnt + CNT_W'(1);
`else
  assign ready_o = 1'b1;
`endif

  assign accept = start_i && ready_o;
  assign zero_o = (result_o == '0);

  // Decode the opcode and form the single-cycle result and flags.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    illegal  = 1'b0;
    is_mul   = 1'b0;
    case (ctrl_i)
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
      OP_NOR: alu_res = ~(src1_i | src2_i);
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      // True sign of A-B is the difference MSB corrected by the overflow.
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
`ifdef ALU_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Control and result registers: accept, single-cycle completion, and the MUL iteration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o     <= 1'b0;
      result_o   <= '0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
`ifdef ALU_MUL_EN
      // NOTE: the multiply datapath registers are cleared too, so an abandoned MUL leaves no residue.
      state      <= S_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      product    <= '0;
      cnt        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the later done_o <= 1 overrides this default.
      done_o <= 1'b0;
      if (accept && !is_mul) begin
        result_o   <= illegal ? '0 : alu_res;
        cout_o     <= alu_cout;
        overflow_o <= alu_ovf;
        err_o      <= illegal;
        done_o     <= 1'b1;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        mcand   <= {{WIDTH{1'b0}}, src1_i};
        mplier  <= src2_i;
        product <= '0;
        cnt     <= '0;
        state   <= S_MUL;
      end
      // start_i is ignored here because accept requires ready_o.
      if (state == S_MUL) begin
        product <= product_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt_next;
        if (cnt_next == CNT_W'(WIDTH)) begin
          result_o   <= product_next[WIDTH-1:0];
          overflow_o <= |product_next[2*WIDTH-1:WIDTH];
          cout_o     <= 1'b0;
          err_o      <= 1'b0;
          done_o     <= 1'b1;
          state      <= S_IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32. MUL scenarios are exercised when
// ALU_MUL_EN is defined; otherwise ctrl 1000 is checked as an illegal opcode.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   ctrl;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         cout_o;
  logic         overflow_o;
  logic         err_o;

  int checks = 0;
  int passes = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .cout_o     (cout_o),
    .overflow_o (overflow_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Observed vector: {ready, done, result, zero, cout, overflow, err}
  wire [37:0] obs = {ready_o, done_o, result_o, zero_o, cout_o, overflow_o, err_o};

  // Present a request at the falling edge; return 1ns after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; ctrl = c; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ctrl = 4'b0000; src1 = '0; src2 = '0;
    #12;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_asserted: got %h expected %h", obs, {1'b1, 1'b0, 32'h0, 4'b1000});
    else passes++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_idle: got %h expected %h", obs, {1'b1, 1'b0, 32'h0, 4'b1000});
    else passes++;
  endtask

  task automatic test_add_sub;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_overflow: got %h expected %h", obs, {2'b11, 32'h8000_0000, 4'b0010});
    else passes++;
    // done_o is a single-cycle pulse; result and flags hold.
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_hold: got %h expected %h", obs, {2'b10, 32'h8000_0000, 4'b0010});
    else passes++;
    issue(4'b0110, 32'd5, 32'd5);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL sub_zero: got %h expected %h", obs, {2'b11, 32'h0, 4'b1100});
    else passes++;
  endtask

  task automatic test_slt_nor;
    issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL slt_overflow_case: got %h expected %h", obs, {2'b11, 32'h1, 4'b0000});
    else passes++;
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL slt_pos_vs_neg: got %h expected %h", obs, {2'b11, 32'h0, 4'b1000});
    else passes++;
    issue(4'b1100, 32'h0, 32'h0);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL nor_zero: got %h expected %h", obs, {2'b11, 32'hFFFF_FFFF, 4'b0000});
    else passes++;
  endtask

  task automatic test_illegal;
    issue(4'b1111, 32'h1234_5678, 32'h1111_1111);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL illegal_1111: got %h expected %h", obs, {2'b11, 32'h0, 4'b1001});
    else passes++;
    // The next legal op clears err_o.
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL illegal_clear: got %h expected %h", obs, {2'b11, 32'h0000_F000, 4'b0000});
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  c_v [3];
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [37:0] e_v [3];
    c_v[0] = 4'b0000; a_v[0] = 32'hFFFF_0000; b_v[0] = 32'h0F0F_0F0F;
    e_v[0] = {1'b1, 1'b1, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    c_v[1] = 4'b0001; a_v[1] = 32'h0000_00F0; b_v[1] = 32'h0000_000F;
    e_v[1] = {1'b1, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0};
    c_v[2] = 4'b0010; a_v[2] = 32'hFFFF_FFFF; b_v[2] = 32'h0000_0001;
    e_v[2] = {1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl = c_v[i]; src1 = a_v[i]; src2 = b_v[i];
      @(posedge clk); #1;
      checks++;
      if (obs !== e_v[i])
        $display("FAIL back_to_back_%0d: got %h expected %h", i, obs, e_v[i]);
      else passes++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL back_to_back_end: got %h expected %h", obs, {2'b10, 32'h0, 4'b1100});
    else passes++;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    logic stall_ok;
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    stall_ok = (ready_o === 1'b0) && (done_o === 1'b0);
    for (int i = 1; i < W; i++) begin
      if (i == 9) begin
        ctrl = 4'b0000; src1 = 32'hFFFF_FFFF; src2 = 32'h0000_00AA; start = 1'b1;
      end
      @(posedge clk); #1;
      if (i == 10) start = 1'b0;
      if (ready_o !== 1'b0 || done_o !== 1'b0) stall_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (stall_ok !== 1'b1)
      $display("FAIL mul_busy_32_cycles: got %b expected 1", stall_ok);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL mul_overflow: got %h expected %h", obs, {2'b11, 32'h0, 4'b1010});
    else passes++;
    // The start pulse during MUL must not have been queued.
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL mul_start_ignored: got %h expected %h", obs, {2'b10, 32'h0, 4'b1010});
    else passes++;
    issue(4'b1000, 32'h0000_FFFF, 32'h0000_0003);
    repeat (W - 1) @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0)
      $display("FAIL mul_early_done: got %b expected 0", done_o);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0002_FFFD, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL mul_small: got %h expected %h", obs, {2'b11, 32'h0002_FFFD, 4'b0000});
    else passes++;
  endtask
`else
  task automatic test_mul;
    issue(4'b1000, 32'h0000_FFFF, 32'h0000_0003);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL mul_disabled_illegal: got %h expected %h", obs, {2'b11, 32'h0, 4'b1001});
    else passes++;
    issue(4'b0001, 32'h0000_0003, 32'h0002_FFFC);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h0002_FFFF, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL mul_disabled_recover: got %h expected %h", obs, {2'b11, 32'h0002_FFFF, 4'b0000});
    else passes++;
  endtask
`endif

  task automatic test_reset_mid_op;
    logic no_done;
`ifdef ALU_MUL_EN
    issue(4'b1000, 32'd7, 32'd9);
    repeat (16) @(posedge clk);
`else
    issue(4'b0010, 32'd7, 32'd9);
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_mid_op: got %h expected %h", obs, {2'b10, 32'h0, 4'b1000});
    else passes++;
    @(negedge clk) rst = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0) no_done = 1'b0;
    end
    checks++;
    if (no_done !== 1'b1 || result_o !== 32'h0)
      $display("FAIL reset_no_done: got done_free=%b result=%h expected 1 and 0", no_done, result_o);
    else passes++;
    issue(4'b0010, 32'd2, 32'd3);
    checks++;
    if (obs !== {1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL after_reset_add: got %h expected %h", obs, {2'b11, 32'd5, 4'b0000});
    else passes++;
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_slt_nor;
    test_illegal;
    test_back_to_back;
    test_mul;
    test_reset_mid_op;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with a start/done handshake: the multi-bit successor to the 1-bit ripple ALU slice. It executes the datapath's logic, add/sub, set-less-than and NOR operations in one cycle, and an optional iterative shift-add multiply over WIDTH cycles. It sits between the register-file read ports and the write-back mux. A controller must wait for `done_o` before consuming `result_o`.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4..64.
- `clk_i` input 1: rising-edge clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: request; sampled only while `ready_o`=1.
- `ctrl_i` input 4: operation select.
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT; 1100 NOR; 1000 MUL.
  - Any other value is illegal.
- `src1_i` input WIDTH: operand A.
- `src2_i` input WIDTH: operand B.
- `ready_o` output 1: block is idle and can accept a request.
- `done_o` output 1: one-cycle pulse; `result_o` and the flags are valid.
- `result_o` output WIDTH: registered result.
- `zero_o` output 1: `result_o` == 0.
- `cout_o` output 1: carry out (ADD/SUB only).
- `overflow_o` output 1: signed overflow (ADD/SUB), or unsigned product overflow (MUL).
- `err_o` output 1: the last accepted `ctrl_i` was illegal.

## Operation
- **States:** IDLE and MUL. `ready_o` = (state == IDLE).
- **Accept.** A request is accepted on a rising edge with `start_i`=1 and state IDLE. `ctrl_i`, `src1_i` and `src2_i` are captured on that edge.
  - A `start_i` in state MUL is ignored. It is not queued.
- **Single-cycle ops.** On the accept edge:
  - `result_o`, `cout_o`, `overflow_o` and `err_o` are loaded.
  - `done_o` is set to 1.
  - State remains IDLE.
- **ADD/SUB.**
  - The sum is A + (B ^ {WIDTH{sub}}) + sub, computed at WIDTH+1 bits; `cout_o` = bit WIDTH.
  - `overflow_o` = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the inverted B for SUB.
- **SLT:** result = {0…0, signed(A) < signed(B)}.
  - The comparison uses the true sign: sub_msb ^ sub_overflow.
  - SLT reports `cout_o`=0 and `overflow_o`=0.
- **AND/OR/NOR:** bitwise; `cout_o`=0, `overflow_o`=0.
- **Illegal op:** result 0, `err_o`=1, `cout_o`=0, `overflow_o`=0. Latency is the same as a single-cycle op.
  - `err_o` clears on the next accepted legal op.
- **MUL** (unsigned). On the accept edge:
  - Load the 2·WIDTH-bit product = 0, multiplicand = A, multiplier = B, cnt = 0.
  - Enter state MUL; `done_o` stays 0.
- **Each edge in state MUL:**
  - If multiplier[0]=1, add the shifted multiplicand to the product.
  - Shift the multiplicand left by one and the multiplier right by one; cnt++.
- **On the edge where cnt reaches WIDTH:**
  - `result_o` = product[WIDTH-1:0].
  - `overflow_o` = |product[2·WIDTH-1:WIDTH]; `cout_o`=0.
  - `done_o`=1; state returns to IDLE.
- **zero_o** is combinational from the registered `result_o`, so it is valid whenever `done_o` is high.
- **Hold.** `result_o` and the flags hold their value until the next completion. `done_o` returns to 0 on the following edge unless another op completes on that edge.

## Timing
- **Reset values.** Any `rst_i`=1, including in mid-operation, asynchronously forces:
  - state IDLE, `ready_o`=1, `done_o`=0;
  - `result_o`=0, `zero_o`=1, `cout_o`=0, `overflow_o`=0, `err_o`=0;
  - cnt and the internal registers to 0.
  - A MUL in progress is abandoned; no `done_o` is produced for it.
- **Latency** is counted from the accept edge t0:
  - Single-cycle ops: `done_o` is high in the cycle after t0.
  - MUL: `done_o` is high in the cycle after edge t0+WIDTH.
- **Throughput.**
  - Single-cycle ops: back-to-back with `start_i` held high, one result per cycle.
  - A new request may be accepted in the same cycle that `done_o` is high.
- **Flag scope:** flags are meaningful only for their own op class, as listed under Operation.

## Configuration
- **`ALU_MUL_EN` defined:** the MUL state, multiplicand, multiplier, product register and counter are compiled in. Behaviour is as described above.
- **`ALU_MUL_EN` undefined:** no MUL datapath and no MUL state exist.
  - `ctrl_i`=1000 is treated as illegal: result 0, `err_o`=1, one-cycle latency.
  - `ready_o` is constantly 1 outside reset.

## Test plan
All scenarios use WIDTH=32.

- **ADD overflow.** ADD 0x7FFFFFFF + 0x00000001 → one cycle later `done_o`=1, `result_o`=0x80000000, `overflow_o`=1, `cout_o`=0, `zero_o`=0.
- **SUB to zero.** SUB 5 − 5 → `result_o`=0, `zero_o`=1, `cout_o`=1, `overflow_o`=0.
- **SLT overflow case.** SLT 0x80000000 vs 0x00000001 → `result_o`=1, even though the subtraction overflows.
- **SLT and NOR.** SLT 0x00000001 vs 0xFFFFFFFF → 0. NOR 0 with 0 → 0xFFFFFFFF.
- **MUL.**
  - 0x00010000 × 0x00010000 → `ready_o`=0 for 32 cycles, then `done_o`=1, `result_o`=0, `overflow_o`=1, `zero_o`=1.
  - 0x0000FFFF × 3 → 0x0002FFFD, `overflow_o`=0.
  - A `start_i` pulsed at cycle 10 of the MUL is ignored.
- **Reset and back-to-back.**
  - Assert `rst_i` mid-MUL (cnt=16) → all outputs return to their reset values immediately, and no `done_o` follows.
  - Back-to-back AND, OR, ADD with `start_i` held high → three consecutive `done_o` cycles.
  - Illegal `ctrl_i`=1111 → `err_o`=1, `result_o`=0.
  - With `ALU_MUL_EN` undefined, ctrl 1000 → `err_o`=1 after one cycle.
